sram_rw_arbiter: RTL and testbench

Two-requester round-robin arbiter and sequencer for the RW port (port 0) of the 1RW1R 32x256 SRAM macro. It zero-fills the macro after reset, then shares port 0 between requester A (core load/store) and requester B (Wishbone/DMA side). It issues at most one access per clock and returns read data with a fixed latency. Port 1 (read-only) of the macro is not touched by this block.

---
 rtl/sram_rw_arbiter.sv | 226 ++++++++++++++++++++++
 tb/tb_sram_rw_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_rw_arbiter.sv
// sram_rw_arbiter
// Zero-fills the RW port of a 1RW1R SRAM macro after reset, then shares that
// port between two requesters with round-robin arbitration. One access per
// clock; read data returns two cycles after the grant.

`timescale 1ns/1ps

module sram_rw_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_WMASKS = 4,
  parameter bit INIT_ZERO  = 1'b1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,

  input  logic                  i_a_req,
  input  logic                  i_a_we,
  input  logic [NUM_WMASKS-1:0] i_a_wmask,
  input  logic [ADDR_WIDTH-1:0] i_a_addr,
  input  logic [DATA_WIDTH-1:0] i_a_wdata,
  output logic                  o_a_gnt,
  output logic                  o_a_rvalid,
  output logic [DATA_WIDTH-1:0] o_a_rdata,

  input  logic                  i_b_req,
  input  logic                  i_b_we,
  input  logic [NUM_WMASKS-1:0] i_b_wmask,
  input  logic [ADDR_WIDTH-1:0] i_b_addr,
  input  logic [DATA_WIDTH-1:0] i_b_wdata,
  output logic                  o_b_gnt,
  output logic                  o_b_rvalid,
  output logic [DATA_WIDTH-1:0] o_b_rdata,

  output logic                  o_init_done,

  output logic                  o_sram_csb0,
  output logic                  o_sram_web0,
  output logic [NUM_WMASKS-1:0] o_sram_wmask0,
  output logic [ADDR_WIDTH-1:0] o_sram_addr0,
  output logic [DATA_WIDTH-1:0] o_sram_din0,
  input  logic [DATA_WIDTH-1:0] i_sram_dout0
);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam state_t          RESET_STATE = INIT_ZERO ? ST_INIT : ST_RUN;
  localparam logic [ADDR_WIDTH-1:0] CNT_MAX = '1;

  state_t                  r_state;
  state_t                  w_nextState;
  logic [ADDR_WIDTH-1:0]   r_cnt;
  logic                    r_last;
  logic                    r_initDone;

  logic                    w_aGnt;
  logic                    w_bGnt;

  logic                    w_csb0;
  logic                    w_web0;
  logic [NUM_WMASKS-1:0]   w_wmask0;
  logic [ADDR_WIDTH-1:0]   w_addr0;
  logic [DATA_WIDTH-1:0]   w_din0;

  logic [NUM_WMASKS-1:0]   r_holdWmask;
  logic [ADDR_WIDTH-1:0]   r_holdAddr;
  logic [DATA_WIDTH-1:0]   r_holdDin;

  logic                    r_rdValid;
  logic                    r_rdId;
  logic                    r_aRvalid;
  logic                    r_bRvalid;
  logic [DATA_WIDTH-1:0]   r_aRdata;
  logic [DATA_WIDTH-1:0]   r_bRdata;

  // State register: INIT sweep or RUN arbitration.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= RESET_STATE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next state: leave INIT once the last address of the sweep has been written.
  always_comb begin
    w_nextState = r_state;
    if (r_state == ST_INIT && r_cnt == CNT_MAX) begin
      w_nextState = ST_RUN;
    end
  end

  // Grant logic: single requester wins outright, a tie goes to whoever was not granted last.
  always_comb begin
    w_aGnt = 1'b0;
    w_bGnt = 1'b0;
    if (i_rst_n && r_state == ST_RUN) begin
      if (i_a_req && i_b_req) begin
        w_aGnt = r_last;
        w_bGnt = ~r_last;
      end else begin
        w_aGnt = i_a_req;
        w_bGnt = i_b_req;
      end
    end
  end

  // Macro port drive: sweep writes in INIT, winner's access on a grant, otherwise idle with held bus.
  always_comb begin
    w_csb0   = 1'b1;
    w_web0   = 1'b1;
    w_wmask0 = r_holdWmask;
    w_addr0  = r_holdAddr;
    w_din0   = r_holdDin;
    if (i_rst_n) begin
      if (r_state == ST_INIT) begin
        w_csb0   = 1'b0;
        w_web0   = 1'b0;
        w_wmask0 = '1;
        w_addr0  = r_cnt;
        w_din0   = '0;
      end else if (w_aGnt) begin
        w_csb0   = 1'b0;
        w_web0   = ~i_a_we;
        w_wmask0 = i_a_we ? i_a_wmask : '0;
        w_addr0  = i_a_addr;
        w_din0   = i_a_wdata;
      end else if (w_bGnt) begin
        w_csb0   = 1'b0;
        w_web0   = ~i_b_we;
        w_wmask0 = i_b_we ? i_b_wmask : '0;
        w_addr0  = i_b_addr;
        w_din0   = i_b_wdata;
      end
    end
  end

  // Remember the last driven mask/address/data so an idle port keeps a quiet bus.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_holdWmask <= '0;
      r_holdAddr  <= '0;
      r_holdDin   <= '0;
    end else if (!w_csb0) begin
      r_holdWmask <= w_wmask0;
      r_holdAddr  <= w_addr0;
      r_holdDin   <= w_din0;
    end
  end

  // Sweep counter advances every INIT cycle and wraps back to 0 on exit.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (r_state == ST_INIT) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // init_done rises on the edge that enters RUN and stays high until reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_initDone <= 1'b0;
    end else if (w_nextState == ST_RUN) begin
      r_initDone <= 1'b1;
    end
  end

  // Round-robin pointer: 0 after an A grant, 1 after a B grant; starts at 1 so A wins the first tie.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_last <= 1'b1;
    end else if (w_aGnt) begin
      r_last <= 1'b0;
    end else if (w_bGnt) begin
      r_last <= 1'b1;
    end
  end

  // First read stage: note that a read was issued this cycle and who owns it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rdValid <= 1'b0;
      r_rdId    <= 1'b0;
    end else begin
      r_rdValid <= (w_aGnt && !i_a_we) || (w_bGnt && !i_b_we);
      r_rdId    <= w_bGnt;
    end
  end

  // Second read stage: capture macro output into the owner's data register and pulse its valid.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_aRvalid <= 1'b0;
      r_bRvalid <= 1'b0;
      r_aRdata  <= '0;
      r_bRdata  <= '0;
    end else begin
      r_aRvalid <= r_rdValid && !r_rdId;
      r_bRvalid <= r_rdValid && r_rdId;
      if (r_rdValid && !r_rdId) begin
        r_aRdata <= i_sram_dout0;
      end
      if (r_rdValid && r_rdId) begin
        r_bRdata <= i_sram_dout0;
      end
    end
  end

  assign o_a_gnt       = w_aGnt;
  assign o_b_gnt       = w_bGnt;
  assign o_a_rvalid    = r_aRvalid;
  assign o_b_rvalid    = r_bRvalid;
  assign o_a_rdata     = r_aRdata;
  assign o_b_rdata     = r_bRdata;
  assign o_init_done   = r_initDone;
  assign o_sram_csb0   = w_csb0;
  assign o_sram_web0   = w_web0;
  assign o_sram_wmask0 = w_wmask0;
  assign o_sram_addr0  = w_addr0;
  assign o_sram_din0   = w_din0;

endmodule

// File: tb/tb_sram_rw_arbiter.sv
// Testbench for sram_rw_arbiter: behavioural RW-port macro model plus a
// read-response scoreboard checked by an independent monitor.

`timescale 1ns/1ps

module tb_sram_rw_arbiter;

  localparam int DW    = 32;
  localparam int AW    = 8;
  localparam int NW    = 4;
  localparam int DEPTH = 256;

  logic clk;
  logic rstN;

  logic          aReq, aWe, aGnt, aRvalid;
  logic [NW-1:0] aWmask;
  logic [AW-1:0] aAddr;
  logic [DW-1:0] aWdata, aRdata;
  logic          bReq, bWe, bGnt, bRvalid;
  logic [NW-1:0] bWmask;
  logic [AW-1:0] bAddr;
  logic [DW-1:0] bWdata, bRdata;
  logic          initDone;
  logic          sramCsb0, sramWeb0;
  logic [NW-1:0] sramWmask0;
  logic [AW-1:0] sramAddr0;
  logic [DW-1:0] sramDin0;
  logic [DW-1:0] sramDout0;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
    string         name;
  } exp_t;

  exp_t expA[$];
  exp_t expB[$];
  bit   gntLog[$];

  sram_rw_arbiter #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .NUM_WMASKS(NW),
    .INIT_ZERO (1'b1)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rstN),
    .i_a_req      (aReq),
    .i_a_we       (aWe),
    .i_a_wmask    (aWmask),
    .i_a_addr     (aAddr),
    .i_a_wdata    (aWdata),
    .o_a_gnt      (aGnt),
    .o_a_rvalid   (aRvalid),
    .o_a_rdata    (aRdata),
    .i_b_req      (bReq),
    .i_b_we       (bWe),
    .i_b_wmask    (bWmask),
    .i_b_addr     (bAddr),
    .i_b_wdata    (bWdata),
    .o_b_gnt      (bGnt),
    .o_b_rvalid   (bRvalid),
    .o_b_rdata    (bRdata),
    .o_init_done  (initDone),
    .o_sram_csb0  (sramCsb0),
    .o_sram_web0  (sramWeb0),
    .o_sram_wmask0(sramWmask0),
    .o_sram_addr0 (sramAddr0),
    .o_sram_din0  (sramDin0),
    .i_sram_dout0 (sramDout0)
  );

  // Free-running clock and a cycle counter used for latency checks.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Macro model: inputs latched at posedge, writes committed and reads driven at the following negedge.
  logic [DW-1:0] mem [DEPTH];
  logic          capValid = 1'b0;
  logic          capWrite = 1'b0;
  logic [NW-1:0] capMask  = '0;
  logic [AW-1:0] capAddr  = '0;
  logic [DW-1:0] capDin   = '0;
  int            writeCount     = 0;
  int            zeroWriteCount = 0;

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'hA5A5_0000 | 32'(i);
    sramDout0 = '0;
  end

  always @(posedge clk) begin
    capValid <= !sramCsb0;
    capWrite <= !sramWeb0;
    capMask  <= sramWmask0;
    capAddr  <= sramAddr0;
    capDin   <= sramDin0;
  end

  always @(negedge clk) begin
    if (capValid) begin
      if (capWrite) begin
        for (int l = 0; l < NW; l++) begin
          if (capMask[l]) mem[capAddr][8*l +: 8] <= capDin[8*l +: 8];
        end
        writeCount++;
        if (capMask == 4'hF && capDin == '0) zeroWriteCount++;
      end else begin
        sramDout0 <= mem[capAddr];
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Monitor: pops the scoreboard on every rvalid, checks grant exclusivity and logs grant order.
  exp_t eA;
  exp_t eB;
  always @(negedge clk) begin
    if (aRvalid) begin
      if (expA.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected a_rvalid: got data 0x%0h, expected no response", aRdata);
      end else begin
        eA = expA.pop_front();
        checkOutput({eA.name, " a_rdata"}, 64'(aRdata), 64'(eA.data));
        checkOutput({eA.name, " a_rvalid cycle"}, 64'(cyc), 64'(eA.cyc));
      end
    end
    if (bRvalid) begin
      if (expB.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected b_rvalid: got data 0x%0h, expected no response", bRdata);
      end else begin
        eB = expB.pop_front();
        checkOutput({eB.name, " b_rdata"}, 64'(bRdata), 64'(eB.data));
        checkOutput({eB.name, " b_rvalid cycle"}, 64'(cyc), 64'(eB.cyc));
      end
    end
    if (aGnt || bGnt) checkOutput("exclusive grant", 64'(aGnt & bGnt), 64'd0);
    if (aGnt) gntLog.push_back(1'b0);
    if (bGnt) gntLog.push_back(1'b1);
  end

  // Drive one request, hold it until granted, then push the expected read response.
  task automatic applyStimulus(input bit isB, input bit we, input logic [NW-1:0] mask,
                               input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                               input logic [DW-1:0] expData, input bit expectResp,
                               input string name, output int gntCyc);
    bit g;
    exp_t e;
    g      = 1'b0;
    gntCyc = -1;
    if (!isB) begin
      aReq = 1'b1; aWe = we; aWmask = mask; aAddr = addr; aWdata = wdata;
    end else begin
      bReq = 1'b1; bWe = we; bWmask = mask; bAddr = addr; bWdata = wdata;
    end
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      g = isB ? bGnt : aGnt;
      if (g) begin
        gntCyc = cyc;
        if (!we && expectResp) begin
          e.data = expData;
          e.cyc  = cyc + 2;
          e.name = name;
          if (!isB) expA.push_back(e);
          else      expB.push_back(e);
        end
      end
      @(posedge clk);
      #1;
      if (g) break;
    end
    if (!g) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL %s grant timeout: got no grant, expected grant within 400 cycles", name);
    end
    if (!isB) aReq = 1'b0;
    else      bReq = 1'b0;
  endtask

  task automatic checkResetState(input string name);
    checkOutput({name, " flags"}, 64'({aGnt, bGnt, aRvalid, bRvalid, initDone, sramCsb0, sramWeb0}), 64'b0000011);
    checkOutput({name, " rdata"}, {aRdata, bRdata}, 64'd0);
    checkOutput({name, " sram bus"}, 64'({sramWmask0, sramAddr0, sramDin0}), 64'd0);
  endtask

  int g0, g1, gTmp, w0, zw0, nonZero, k;
  logic [3:0] order;

  initial begin
    rstN = 1'b0;
    aReq = 1'b0; aWe = 1'b0; aWmask = '0; aAddr = '0; aWdata = '0;
    bReq = 1'b0; bWe = 1'b0; bWmask = '0; bAddr = '0; bWdata = '0;

    repeat (2) @(negedge clk);
    checkResetState("reset");

    // A already requests a write while still in reset
    aReq = 1'b1; aWe = 1'b1; aWmask = 4'hF; aAddr = 8'h05; aWdata = 32'hCAFE_F00D;
    @(negedge clk);
    checkOutput("gnt held low in reset", 64'(aGnt), 64'd0);

    @(posedge clk);
    #1;
    rstN = 1'b1;
    w0   = writeCount;
    zw0  = zeroWriteCount;

    for (int c = 0; c < DEPTH; c++) begin
      @(negedge clk);
      checkOutput($sformatf("init sweep cycle %0d", c),
                  64'({initDone, aGnt, sramCsb0, sramWeb0, sramWmask0, sramAddr0, sramDin0}),
                  64'({1'b0, 1'b0, 1'b0, 1'b0, 4'hF, 8'(c), 32'h0}));
    end

    @(negedge clk);
    checkOutput("init_done at cycle 256", 64'(initDone), 64'd1);
    checkOutput("A write granted first RUN cycle",
                64'({aGnt, sramCsb0, sramWeb0, sramWmask0, sramAddr0, sramDin0}),
                64'({1'b1, 1'b0, 1'b0, 4'hF, 8'h05, 32'hCAFE_F00D}));
    @(posedge clk);
    #1;
    aReq = 1'b0;
    checkOutput("sweep write count", 64'(writeCount - w0), 64'd256);
    checkOutput("sweep zero full-mask writes", 64'(zeroWriteCount - zw0), 64'd256);
    nonZero = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] != '0) nonZero++;
    checkOutput("memory zero after sweep", 64'(nonZero), 64'd0);

    // Write issued during INIT survives the sweep
    applyStimulus(1'b0, 1'b0, 4'h0, 8'h05, 32'h0, 32'hCAFE_F00D, 1'b1, "init-time write readback", gTmp);

    // Back-to-back write then read by A
    applyStimulus(1'b0, 1'b1, 4'hF, 8'h10, 32'hDEAD_BEEF, 32'h0, 1'b0, "A write 0x10", g0);
    applyStimulus(1'b0, 1'b0, 4'h0, 8'h10, 32'h0, 32'hDEAD_BEEF, 1'b1, "A read 0x10", g1);
    checkOutput("A back-to-back grant", 64'(g1 - g0), 64'd1);

    // Zero-filled location read by B
    applyStimulus(1'b1, 1'b0, 4'h0, 8'h33, 32'h0, 32'h0, 1'b1, "B read 0x33", gTmp);

    // Byte-masked write by B
    applyStimulus(1'b1, 1'b1, 4'b0101, 8'h20, 32'h1122_3344, 32'h0, 1'b0, "B masked write", gTmp);
    applyStimulus(1'b1, 1'b0, 4'hF, 8'h20, 32'h5555_AAAA, 32'h0022_0044, 1'b1, "B read 0x20", gTmp);
    @(negedge clk);
    checkOutput("idle bus holds last read",
                64'({sramCsb0, sramWeb0, sramWmask0, sramAddr0, sramDin0}),
                64'({1'b1, 1'b1, 4'h0, 8'h20, 32'h5555_AAAA}));
    repeat (4) @(posedge clk);
    #1;

    // Contention: B was granted last, so A wins the first tie and grants alternate
    gntLog.delete();
    fork
      begin
        int ga;
        applyStimulus(1'b0, 1'b0, 4'h0, 8'h10, 32'h0, 32'hDEAD_BEEF, 1'b1, "contend A 0x10", ga);
        applyStimulus(1'b0, 1'b0, 4'h0, 8'h05, 32'h0, 32'hCAFE_F00D, 1'b1, "contend A 0x05", ga);
      end
      begin
        int gb;
        applyStimulus(1'b1, 1'b0, 4'h0, 8'h20, 32'h0, 32'h0022_0044, 1'b1, "contend B 0x20", gb);
        applyStimulus(1'b1, 1'b0, 4'h0, 8'h33, 32'h0, 32'h0, 1'b1, "contend B 0x33", gb);
      end
    join
    checkOutput("contention grant count", 64'(gntLog.size()), 64'd4);
    order = 4'hF;
    if (gntLog.size() >= 4) order = {gntLog[0], gntLog[1], gntLog[2], gntLog[3]};
    checkOutput("contention grant order A,B,A,B", 64'(order), 64'b0101);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("scoreboard drained", 64'(expA.size() + expB.size()), 64'd0);

    // Mid-operation reset: the in-flight read must vanish
    applyStimulus(1'b0, 1'b0, 4'h0, 8'h10, 32'h0, 32'h0, 1'b0, "A read before reset", gTmp);
    rstN = 1'b0;
    @(negedge clk);
    checkResetState("mid-op reset");
    repeat (3) @(negedge clk);
    checkResetState("mid-op reset held");
    @(posedge clk);
    #1;
    rstN = 1'b1;
    @(negedge clk);
    checkOutput("sweep restart cycle 0",
                64'({initDone, sramCsb0, sramWeb0, sramAddr0}), 64'({1'b0, 1'b0, 1'b0, 8'h00}));
    @(negedge clk);
    checkOutput("sweep restart cycle 1", 64'({initDone, sramAddr0}), 64'({1'b0, 8'h01}));
    k = 2;
    while (k < 400 && !initDone) begin
      @(negedge clk);
      if (!initDone) k++;
    end
    checkOutput("init_done cycle after re-reset", 64'(k), 64'd256);
    @(posedge clk);
    #1;

    applyStimulus(1'b1, 1'b0, 4'h0, 8'h10, 32'h0, 32'h0, 1'b1, "B read 0x10 after re-sweep", gTmp);
    applyStimulus(1'b0, 1'b0, 4'h0, 8'h05, 32'h0, 32'h0, 1'b1, "A read 0x05 after re-sweep", gTmp);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("final scoreboard drained", 64'(expA.size() + expB.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
